lcd_string_streamer: RTL and testbench

//  Parametrised replacement for hand-unrolled per-character LCD instruction sequences.

---
 rtl/lcd_stream_pkg.sv | 17 +
 rtl/lcd_char_ram.sv | 24 ++
 rtl/lcd_string_streamer.sv | 156 +++++++++++++++
 tb/tb_lcd_string_streamer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stream_pkg.sv
// Shared FSM encoding and LCD byte constants for the LCD string streamer.
package lcd_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_CMD,
    ST_DONE
  } state_e;

  localparam logic [7:0] LCD_CMD_HOME  = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic       RS_DATA       = 1'b1;
  localparam logic       RS_CMD        = 1'b0;

endpackage

// File: rtl/lcd_char_ram.sv
// Character buffer: one write port, one synchronous read port with read enable.
module lcd_char_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read data is only refreshed on rd_en so it stays stable while a byte waits for ready.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/lcd_string_streamer.sv
// Streams a buffered string to an LCD controller over valid/ready, with optional repeat.
// Optional line-wrap commands are enabled by defining LCD_STREAM_LINE_WRAP_EN.
module lcd_string_streamer
  import lcd_stream_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int LCD_COLS = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iWrEnable,
  input  logic [ADDR_W-1:0] iWrAddress,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [ADDR_W:0]   iLength,
  input  logic              iStart,
  input  logic              iRepeat,
  output logic              oBusy,
  output logic              oDone,
  output logic [ADDR_W-1:0] oCharIndex,
  output logic              oLCD_Valid,
  output logic              oLCD_RS,
  output logic [DATA_W-1:0] oLCD_Data,
  input  logic              iLCD_Ready
);

  // state | meaning: IDLE wait start | FETCH buffer read | SEND offer char
  //                  CMD offer command byte | DONE pulse oDone, repeat or finish
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] rd_data;
  logic              last_char;

`ifdef LCD_STREAM_LINE_WRAP_EN
  localparam int COL_W = $clog2(LCD_COLS + 1);
  logic [COL_W-1:0] col_q, col_d;
  logic             line2_q, line2_d;
`endif

  lcd_char_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i    (Clock),
    .wr_en_i  (iWrEnable),
    .wr_addr_i(iWrAddress),
    .wr_data_i(iWrData),
    .rd_en_i  (state_q == ST_FETCH),
    .rd_addr_i(index_q[ADDR_W-1:0]),
    .rd_data_o(rd_data)
  );

  assign last_char = (index_q + IDX_ONE) == len_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
`ifdef LCD_STREAM_LINE_WRAP_EN
      col_q   <= '0;
      line2_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
`ifdef LCD_STREAM_LINE_WRAP_EN
      col_q   <= col_d;
      line2_q <= line2_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
`ifdef LCD_STREAM_LINE_WRAP_EN
    col_d   = col_q;
    line2_d = line2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          len_d   = (iLength > DEPTH_LEN) ? DEPTH_LEN : iLength;
          index_d = '0;
`ifdef LCD_STREAM_LINE_WRAP_EN
          col_d   = '0;
          line2_d = 1'b0;
`endif
          state_d = (iLength == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (iLCD_Ready) begin
          index_d = index_q + IDX_ONE;
          if (last_char) begin
            state_d = ST_DONE;
`ifdef LCD_STREAM_LINE_WRAP_EN
          end else if (col_q == COL_W'(LCD_COLS - 1)) begin
            col_d   = '0;
            line2_d = !line2_q;
            cmd_d   = line2_q ? DATA_W'(LCD_CMD_HOME) : DATA_W'(LCD_CMD_LINE2);
            state_d = ST_CMD;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_FETCH;
`else
          end else begin
            state_d = ST_FETCH;
`endif
          end
        end
      end
      // A zero-length repeating message only ever emits the home command.
      ST_CMD: begin
        if (iLCD_Ready) state_d = (len_q == '0) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        if (iRepeat) begin
          index_d = '0;
          cmd_d   = DATA_W'(LCD_CMD_HOME);
`ifdef LCD_STREAM_LINE_WRAP_EN
          col_d   = '0;
          line2_d = 1'b0;
`endif
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oBusy      = (state_q != ST_IDLE);
  assign oDone      = (state_q == ST_DONE);
  assign oLCD_Valid = (state_q == ST_SEND) || (state_q == ST_CMD);
  assign oLCD_RS    = (state_q == ST_SEND) ? RS_DATA : RS_CMD;
  assign oLCD_Data  = (state_q == ST_SEND) ? rd_data :
                      (state_q == ST_CMD)  ? cmd_q   : '0;
  assign oCharIndex = index_q[ADDR_W] ? '1 : index_q[ADDR_W-1:0];

endmodule

// File: tb/tb_lcd_string_streamer.sv
// Directed, table-driven bench for lcd_string_streamer (default or line-wrap build).
module tb_lcd_string_streamer;
  import lcd_stream_pkg::*;

  localparam int DEPTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int LCD_COLS = 16;
`ifdef LCD_STREAM_LINE_WRAP_EN
  localparam int WRAP = 1;
`else
  localparam int WRAP = 0;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              iWrEnable = 1'b0;
  logic [ADDR_W-1:0] iWrAddress = '0;
  logic [DATA_W-1:0] iWrData = '0;
  logic [ADDR_W:0]   iLength = '0;
  logic              iStart = 1'b0;
  logic              iRepeat = 1'b0;
  logic              oBusy, oDone, oLCD_Valid, oLCD_RS;
  logic [ADDR_W-1:0] oCharIndex;
  logic [DATA_W-1:0] oLCD_Data;
  logic              iLCD_Ready = 1'b1;

  lcd_string_streamer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LCD_COLS(LCD_COLS)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iWrEnable(iWrEnable), .iWrAddress(iWrAddress), .iWrData(iWrData),
    .iLength(iLength), .iStart(iStart), .iRepeat(iRepeat),
    .oBusy(oBusy), .oDone(oDone), .oCharIndex(oCharIndex),
    .oLCD_Valid(oLCD_Valid), .oLCD_RS(oLCD_RS), .oLCD_Data(oLCD_Data),
    .iLCD_Ready(iLCD_Ready)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_mem [DEPTH];
  logic [8:0] xfer_q [$];
  logic [8:0] exp_q [$];
  int done_cnt = 0;
  int hold_err = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [8:0] pd = '0;

  // Transfers and oDone pulses are recorded from pre-edge values at each rising edge.
  always @(posedge Clock) begin
    if (!Reset) begin
      if (pv && !pr && !(oLCD_Valid && ({oLCD_RS, oLCD_Data} == pd))) hold_err++;
      if (oLCD_Valid && iLCD_Ready) xfer_q.push_back({oLCD_RS, oLCD_Data});
      if (oDone) done_cnt++;
    end
    pv = oLCD_Valid && !Reset;
    pr = iLCD_Ready;
    pd = {oLCD_RS, oLCD_Data};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_buf();
    string hello = "HELLO WORLD";
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = (i < 11) ? hello[i] : 8'(8'h61 + i - 11);
      @(negedge Clock);
      iWrEnable  = 1'b1;
      iWrAddress = ADDR_W'(i);
      iWrData    = exp_mem[i];
    end
    @(negedge Clock);
    iWrEnable = 1'b0;
  endtask

  task automatic start(input int len);
    @(negedge Clock);
    xfer_q.delete();
    done_cnt = 0;
    iLength  = (ADDR_W+1)'(len);
    iStart   = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (oBusy && c < 800) begin
      @(negedge Clock);
      c++;
    end
    check({tag, " idle"}, oBusy, 0);
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int c = 0;
    while (xfer_q.size() < n && c < 800) begin
      @(negedge Clock);
      c++;
    end
    check({tag, " reached"}, (xfer_q.size() >= n), 1);
  endtask

  task automatic build_exp(input int len, input int rounds);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    for (int r = 0; r < rounds; r++) begin
      if (r > 0) exp_q.push_back({RS_CMD, LCD_CMD_HOME});
      for (int d = 0; d < n; d++) begin
        exp_q.push_back({RS_DATA, exp_mem[d]});
        if (WRAP != 0 && ((d + 1) % LCD_COLS) == 0 && (d + 1) < n)
          exp_q.push_back({RS_CMD, ((((d + 1) / LCD_COLS) % 2) == 1) ? LCD_CMD_LINE2 : LCD_CMD_HOME});
      end
    end
  endtask

  task automatic compare_seq(input string tag);
    int m;
    check({tag, " count"}, xfer_q.size(), exp_q.size());
    m = (xfer_q.size() < exp_q.size()) ? xfer_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s byte%0d", tag, i), xfer_q[i], exp_q[i]);
  endtask

  typedef struct {
    int len;
    int n_data;
    int n_cmd;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int nd, nc;
    vecs[0] = '{11, 11, 0};
    vecs[1] = '{0,  0,  0};
    vecs[2] = '{40, 32, WRAP};
    vecs[3] = '{20, 20, WRAP};
    vecs[4] = '{1,  1,  0};
    vecs[5] = '{16, 16, 0};
    vecs[6] = '{17, 17, WRAP};

    repeat (3) @(negedge Clock);
    check("rst busy",  oBusy, 0);
    check("rst done",  oDone, 0);
    check("rst valid", oLCD_Valid, 0);
    check("rst rs",    oLCD_RS, 0);
    check("rst data",  oLCD_Data, 0);
    check("rst index", oCharIndex, 0);
    Reset = 1'b0;
    load_buf();

    // First valid two cycles after start, zero length gives oDone next cycle
    start(3);
    check("t busy", oBusy, 1);
    check("t fetch valid", oLCD_Valid, 0);
    @(negedge Clock);
    check("t valid", oLCD_Valid, 1);
    check("t rs", oLCD_RS, 1);
    check("t data", oLCD_Data, exp_mem[0]);
    check("t index", oCharIndex, 0);
    wait_idle("t");
    start(0);
    check("len0 done", oDone, 1);
    check("len0 valid", oLCD_Valid, 0);
    @(negedge Clock);
    check("len0 done drop", oDone, 0);
    check("len0 busy drop", oBusy, 0);

    for (int v = 0; v < 7; v++) begin
      start(vecs[v].len);
      wait_idle($sformatf("vec%0d", v));
      nd = 0;
      nc = 0;
      foreach (xfer_q[i]) if (xfer_q[i][8]) nd++; else nc++;
      check($sformatf("vec%0d n_data", v), nd, vecs[v].n_data);
      check($sformatf("vec%0d n_cmd", v), nc, vecs[v].n_cmd);
      check($sformatf("vec%0d done", v), done_cnt, 1);
      build_exp(vecs[v].len, 1);
      compare_seq($sformatf("vec%0d", v));
    end

    // Back-pressure for 5 cycles mid-message
    start(11);
    wait_xfers(4, "stall");
    iLCD_Ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      check($sformatf("stall valid%0d", k), oLCD_Valid, 1);
      check($sformatf("stall data%0d", k), {oLCD_RS, oLCD_Data}, {1'b1, exp_mem[4]});
      check($sformatf("stall index%0d", k), oCharIndex, 4);
    end
    iLCD_Ready = 1'b1;
    wait_idle("stall");
    build_exp(11, 1);
    compare_seq("stall");
    check("stall hold", hold_err, 0);

    // Repeat once, then drop iRepeat
    iRepeat = 1'b1;
    start(3);
    wait_xfers(7, "rep");
    iRepeat = 1'b0;
    wait_idle("rep");
    build_exp(3, 2);
    compare_seq("rep");
    check("rep done", done_cnt, 2);

    // Reset while a char is offered
    iLCD_Ready = 1'b0;
    start(5);
    @(negedge Clock);
    check("mrst pre valid", oLCD_Valid, 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("mrst valid", oLCD_Valid, 0);
    check("mrst busy", oBusy, 0);
    check("mrst done", oDone, 0);
    check("mrst rs", oLCD_RS, 0);
    check("mrst data", oLCD_Data, 0);
    check("mrst index", oCharIndex, 0);
    iLCD_Ready = 1'b1;
    repeat (3) @(negedge Clock);
    check("mrst no xfer", xfer_q.size(), 0);
    start(2);
    wait_idle("mrst2");
    build_exp(2, 1);
    compare_seq("mrst2");
    check("final hold", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
